// File: rtl/polyphase_sched.sv
// Scheduler that time-multiplexes one subfilter across the even, odd and added
// branches of a 2-parallel polyphase FIR, with four-phase handshakes on every side.
module polyphase_sched #(
  parameter int DWIDTH  = 16,
  parameter int DDWIDTH = 2*DWIDTH
) (
  input  logic               clk,
  input  logic               rst,
  output logic               req_in,
  input  logic               ack_in,
  input  logic [DDWIDTH-1:0] data_in,
  output logic               req_out,
  input  logic               ack_out,
  output logic [DDWIDTH-1:0] data_out,
  input  logic               sf_req_in,
  output logic               sf_ack_in,
  output logic [DWIDTH-1:0]  sf_data_in,
  input  logic               sf_req_out,
  output logic               sf_ack_out,
  input  logic [DWIDTH-1:0]  sf_data_out,
  output logic [1:0]         bank_sel,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_INLO = 3'd1,
    S_FEED = 3'd2,
    S_FLO  = 3'd3,
    S_COLL = 3'd4,
    S_CLO  = 3'd5,
    S_OUT  = 3'd6,
    S_OLO  = 3'd7
  } state_t;

  typedef struct packed {
    state_t              state;
    logic                req_in;
    logic                req_out;
    logic                sf_ack_in;
    logic                sf_ack_out;
    logic [1:0]          b;
    logic [DWIDTH-1:0]   a0;
    logic [DWIDTH-1:0]   a1;
    logic [DWIDTH-1:0]   prev_a1;
    logic [DWIDTH-1:0]   x0;
    logic [DWIDTH-1:0]   x1;
    logic [DWIDTH-1:0]   x2;
    logic [DWIDTH-1:0]   y0;
    logic [DWIDTH-1:0]   y1;
    logic [DWIDTH-1:0]   y2;
    logic [DWIDTH-1:0]   sf_data_in;
    logic [DDWIDTH-1:0]  data_out;
    logic [15:0]         frame_cnt;
  } regs_t;

  regs_t             r_q, r_d;
  logic [DWIDTH-1:0] x_sel;

  // Branch input for the bank currently being served.
  always_comb begin
    case (r_q.b)
      2'd0:    x_sel = r_q.x0;
      2'd1:    x_sel = r_q.x1;
      default: x_sel = r_q.x2;
    endcase
  end

  always_comb begin
    // NOTE: r_d takes the full current state first so every path assigns every
    // field; a missing branch then means "hold", never an inferred latch.
    r_d = r_q;
    case (r_q.state)
      S_REQ: begin
        r_d.req_in = 1'b1;
        if (r_q.req_in && ack_in) begin
          r_d.a0     = data_in[DDWIDTH-1 -: DWIDTH];
          r_d.a1     = data_in[DWIDTH-1:0];
          r_d.req_in = 1'b0;
          r_d.state  = S_INLO;
        end
      end
      S_INLO: begin
        if (!ack_in) begin
          r_d.x0      = r_q.a1 - r_q.a0;
          r_d.x1      = r_q.prev_a1 - r_q.a0;
          r_d.x2      = r_q.a0;
          r_d.prev_a1 = r_q.a1;
          r_d.b       = 2'd0;
          r_d.state   = S_FEED;
        end
      end
      // A result offered while feeding is ignored; the feed always wins.
      S_FEED: begin
        if (sf_req_in) begin
          r_d.sf_data_in = x_sel;
          r_d.sf_ack_in  = 1'b1;
          r_d.state      = S_FLO;
        end
      end
      S_FLO: begin
        if (!sf_req_in) begin
          r_d.sf_ack_in = 1'b0;
          r_d.state     = S_COLL;
        end
      end
      S_COLL: begin
        if (sf_req_out) begin
          case (r_q.b)
            2'd0:    r_d.y0 = sf_data_out;
            2'd1:    r_d.y1 = sf_data_out;
            default: r_d.y2 = sf_data_out;
          endcase
          r_d.sf_ack_out = 1'b1;
          r_d.state      = S_CLO;
        end
      end
      S_CLO: begin
        if (!sf_req_out) begin
          r_d.sf_ack_out = 1'b0;
          if (r_q.b == 2'd2) begin
            r_d.state = S_OUT;
          end else begin
            r_d.b     = r_q.b + 2'd1;
            r_d.state = S_FEED;
          end
        end
      end
      // First cycle presents the recombined frame; the ack is only honoured once req_out is up.
      S_OUT: begin
        if (!r_q.req_out) begin
          r_d.req_out  = 1'b1;
          r_d.data_out = {r_q.y1 + r_q.y2, r_q.y0 + r_q.y2};
        end else if (ack_out) begin
          r_d.req_out   = 1'b0;
          r_d.frame_cnt = r_q.frame_cnt + 16'd1;
          r_d.state     = S_OLO;
        end
      end
      S_OLO: begin
        if (!ack_out) r_d.state = S_REQ;
      end
      default: r_d.state = S_REQ;
    endcase
  end

  // NOTE: every register, data included, is cleared by reset so a frame cut
  // short mid-flight leaves nothing behind; S_REQ is encoded as zero.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignment for all state so every register sees the
    // pre-edge values of the others.
    if (!rst) r_q <= '0;
    else      r_q <= r_d;
  end

  assign req_in     = r_q.req_in;
  assign req_out    = r_q.req_out;
  assign data_out   = r_q.data_out;
  assign sf_ack_in  = r_q.sf_ack_in;
  assign sf_ack_out = r_q.sf_ack_out;
  assign sf_data_in = r_q.sf_data_in;
  assign bank_sel   = r_q.b;
  assign frame_cnt  = r_q.frame_cnt;

endmodule

// File: tb/tb_polyphase_sched.sv
// Bench for polyphase_sched: behavioural source, subfilter and sink partners with
// programmable handshake delays, checked against an arithmetic frame model.
module tb_polyphase_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_in;
  logic        ack_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        req_out;
  logic        ack_out = 1'b0;
  logic [31:0] data_out;
  logic        sf_req_in = 1'b0;
  logic        sf_ack_in;
  logic [15:0] sf_data_in;
  logic        sf_req_out = 1'b0;
  logic        sf_ack_out;
  logic [15:0] sf_data_out = '0;
  logic [1:0]  bank_sel;
  logic [15:0] frame_cnt;

  polyphase_sched #(.DWIDTH(16), .DDWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
    .req_out(req_out), .ack_out(ack_out), .data_out(data_out),
    .sf_req_in(sf_req_in), .sf_ack_in(sf_ack_in), .sf_data_in(sf_data_in),
    .sf_req_out(sf_req_out), .sf_ack_out(sf_ack_out), .sf_data_out(sf_data_out),
    .bank_sel(bank_sel), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Partner controls, written by the main sequence only.
  int max_dly  = 0;
  bit sf_ident = 1'b1;
  bit spur     = 1'b0;
  bit sf_hold  = 1'b0;

  logic [31:0] frm[$];
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  logic [1:0]  bank_log[$];
  logic [15:0] xin_log[$];
  int          src_idx = 0;
  int          bank_bad = 0;
  int          t_ack = 0;
  int          lat_last = -1;
  bit          sf_holding = 1'b0;
  logic [15:0] m_prev = '0;

  function automatic int rnd_dly();
    return (max_dly == 0) ? 0 : int'($urandom_range(0, max_dly));
  endfunction

  function automatic logic [15:0] sf_fn(input logic [1:0] bk, input logic [15:0] x);
    logic [15:0] k;
    if (sf_ident) return x;
    case (bk)
      2'd0:    k = 16'd3;
      2'd1:    k = 16'hFFFB;
      default: k = 16'd11;
    endcase
    return x * k + {14'd0, bk} * 16'd7;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame model straight from the polyphase recombination equations.
  task automatic model(input logic [31:0] f);
    logic [15:0] a0, a1, b0, b1;
    a0 = f[31:16];
    a1 = f[15:0];
    b0 = sf_fn(2'd1, m_prev - a0) + sf_fn(2'd2, a0);
    b1 = sf_fn(2'd0, a1 - a0) + sf_fn(2'd2, a0);
    m_prev = a1;
    exp_q.push_back({b0, b1});
  endtask

  task automatic send(input logic [31:0] f);
    frm.push_back(f);
    model(f);
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && got.size() < n; i++) @(negedge clk);
    check(tag, got.size(), n);
  endtask

  // Upstream source.
  int src_dly = 0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      ack_in  = 1'b0;
      src_dly = 0;
    end else if (!ack_in) begin
      if (req_in && src_idx < frm.size()) begin
        if (src_dly > 0) src_dly--;
        else begin
          data_in = frm[src_idx];
          src_idx++;
          ack_in  = 1'b1;
          t_ack   = cyc;
          src_dly = rnd_dly();
        end
      end
    end else if (!req_in) begin
      if (src_dly > 0) src_dly--;
      else begin
        ack_in  = 1'b0;
        src_dly = rnd_dly();
      end
    end
  end

  // Subfilter: 0 raise req_in, 1 take sample, 2 produce result, 3 drop result, 4 wait ack low.
  int          sf_ph = 0;
  int          sf_dly = 0;
  logic [15:0] sf_x = '0;
  logic [1:0]  sf_bank = '0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      sf_req_in   = 1'b0;
      sf_req_out  = 1'b0;
      sf_data_out = '0;
      sf_ph       = 0;
      sf_dly      = 0;
      sf_holding  = 1'b0;
    end else begin
      if (sf_ph == 4 && !sf_ack_out) sf_ph = 0;
      case (sf_ph)
        0: begin
          if (sf_dly > 0) sf_dly--;
          else begin
            sf_req_in = 1'b1;
            if (spur) begin
              sf_req_out  = 1'b1;
              sf_data_out = 16'hDEAD;
            end
            sf_ph  = 1;
            sf_dly = rnd_dly();
          end
        end
        1: if (sf_ack_in) begin
          if (sf_dly > 0) sf_dly--;
          else begin
            sf_x    = sf_data_in;
            sf_bank = bank_sel;
            bank_log.push_back(bank_sel);
            xin_log.push_back(sf_data_in);
            sf_req_in  = 1'b0;
            sf_req_out = 1'b0;
            sf_ph      = 2;
            sf_dly     = rnd_dly();
          end
        end
        2: if (!sf_ack_in) begin
          if (sf_hold && sf_bank == 2'd2) sf_holding = 1'b1;
          else if (sf_dly > 0) sf_dly--;
          else begin
            sf_data_out = sf_fn(sf_bank, sf_x);
            sf_req_out  = 1'b1;
            sf_ph       = 3;
            sf_dly      = rnd_dly();
          end
        end
        3: if (sf_ack_out) begin
          if (bank_sel !== sf_bank) bank_bad++;
          if (sf_dly > 0) sf_dly--;
          else begin
            sf_req_out = 1'b0;
            sf_ph      = 4;
            sf_dly     = rnd_dly();
          end
        end
        default: ;
      endcase
    end
  end

  // Downstream sink.
  int snk_dly = 0;
  bit seen = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      ack_out = 1'b0;
      snk_dly = 0;
      seen    = 1'b0;
    end else if (!ack_out) begin
      if (req_out) begin
        if (!seen) begin
          seen     = 1'b1;
          lat_last = cyc - t_ack;
        end
        if (snk_dly > 0) snk_dly--;
        else begin
          got.push_back(data_out);
          ack_out = 1'b1;
          seen    = 1'b0;
          snk_dly = rnd_dly();
        end
      end
    end else if (!req_out) begin
      if (snk_dly > 0) snk_dly--;
      else begin
        ack_out = 1'b0;
        snk_dly = rnd_dly();
      end
    end
  end

  initial begin
    int base;
    logic [31:0] f;
    rst = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_in", req_in, 0);
    check("rst_req_out", req_out, 0);
    check("rst_sf_ack_in", sf_ack_in, 0);
    check("rst_sf_ack_out", sf_ack_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    check("release_req_in", req_in, 1);

    // Identity subfilter, directed frames
    send({16'd3, 16'd5});
    wait_got(1, 500, "wait_f1");
    check("f1_data_out", got[0], 32'h0000_0005);
    check("f1_bank0", bank_log[0], 0);
    check("f1_bank1", bank_log[1], 1);
    check("f1_bank2", bank_log[2], 2);
    check("f1_x0", xin_log[0], 16'd2);
    check("f1_x1", xin_log[1], 16'hFFFD);
    check("f1_x2", xin_log[2], 16'd3);

    send({16'd1, 16'd4});
    wait_got(2, 500, "wait_f2");
    check("f2_data_out", got[1], 32'h0005_0004);
    check("f2_x0", xin_log[3], 16'd3);
    check("f2_x1", xin_log[4], 16'd4);
    check("f2_x2", xin_log[5], 16'd1);
    repeat (3) @(negedge clk);
    check("f2_frame_cnt", frame_cnt, 2);
    check("f2_data_held", data_out, 32'h0005_0004);

    spur = 1'b1;
    send({16'h8000, 16'h7FFF});
    wait_got(3, 500, "wait_f3");
    check("wrap_x0", xin_log[6], 16'hFFFF);
    check("wrap_data_out", got[2], 32'h0004_7FFF);

    // Spurious results while feeding, zero-delay latency
    sf_ident = 1'b0;
    send($urandom);
    wait_got(4, 500, "wait_f4");
    check("spur_data_out", got[3], exp_q[3]);
    check("latency", lat_last, 15);
    spur = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while collecting the added branch
    sf_hold = 1'b1;
    frm.push_back({16'd10, 16'd20});
    for (int i = 0; i < 500 && !sf_holding; i++) @(negedge clk);
    check("hold_reached", sf_holding, 1);
    check("pre_rst_bank_sel", bank_sel, 2);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_req_in", req_in, 0);
    check("async_req_out", req_out, 0);
    check("async_sf_ack_in", sf_ack_in, 0);
    check("async_sf_ack_out", sf_ack_out, 0);
    check("async_sf_data_in", sf_data_in, 0);
    check("async_data_out", data_out, 0);
    check("async_bank_sel", bank_sel, 0);
    check("async_frame_cnt", frame_cnt, 0);
    sf_hold = 1'b0;
    m_prev  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rerelease_req_in", req_in, 1);

    // Randomised partner delays over 200 frames
    max_dly = 7;
    base = got.size();
    for (int i = 0; i < 200; i++) begin
      f = $urandom;
      send(f);
    end
    wait_got(base + 200, 60000, "wait_random");
    for (int i = 0; i < 200; i++) check("rand_frame", got[base + i], exp_q[base + i]);
    repeat (40) @(negedge clk);
    check("rand_no_dup", got.size(), base + 200);
    check("rand_frame_cnt", frame_cnt, 200);
    check("bank_stable", bank_bad, 0);
    for (int i = 0; i < bank_log.size(); i++) check("bank_order", bank_log[i], i % 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
